// File: rtl/fpaddsub_arbiter.sv
// Round-robin front end sharing one pipelined FP add/sub unit among NREQ requesters.
// A tag pipeline tracks the owner of each issued operation and routes the result back.
module fpaddsub_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ-1:0]      req_op,
   input  logic                 hold,
   output logic [31:0]          fpu_a,
   output logic [31:0]          fpu_b,
   output logic                 fpu_op,
   input  logic [31:0]          fpu_result,
   input  logic [4:0]           fpu_flags,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_result,
   output logic [4:0]           rsp_flags,
   output logic                 busy
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [31:0]    a_arr [NREQ];
   logic [31:0]    b_arr [NREQ];
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] idx;
   logic           gnt_found;
   logic           accept;
   logic [31:0]    sel_a;
   logic [31:0]    sel_b;
   logic           sel_op;
   logic [LAT:0]   tag_vld_p;
   logic [IDW-1:0] tag_id_p [0:LAT];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[32*i +: 32];
      assign b_arr[i] = req_b[32*i +: 32];
   end

   // Grant: first valid requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      req_ready = '0;
      gnt_id    = '0;
      ptr_nxt   = ptr;
      gnt_found = 1'b0;
      idx       = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_op    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found      = 1'b1;
            req_ready[idx] = 1'b1;
            gnt_id         = idx;
            ptr_nxt        = IDW'((int'(idx) + 1) % NREQ);
            sel_a          = a_arr[idx];
            sel_b          = b_arr[idx];
            sel_op         = req_op[idx];
         end
      end
      if (rst || hold) begin
         req_ready = '0;
         gnt_found = 1'b0;
      end
   end

   assign accept = gnt_found;

   // Stage p0..pLAT: issue registers, tag valid shift and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         tag_vld_p  <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_op     <= 1'b0;
      end else begin
         if (accept) begin
            ptr    <= ptr_nxt;
            fpu_a  <= sel_a;
            fpu_b  <= sel_b;
            fpu_op <= sel_op;
         end
         tag_vld_p[0] <= accept;
         for (int k = 1; k <= LAT; k++)
            tag_vld_p[k] <= tag_vld_p[k-1];
         rsp_valid <= '0;
         if (tag_vld_p[LAT]) begin
            rsp_valid[tag_id_p[LAT]] <= 1'b1;
            rsp_result               <= fpu_result;
            rsp_flags                <= fpu_flags;
         end
      end
   end

   // Owner ids only matter where the matching valid bit is set, so they carry no reset
   always_ff @(posedge clk) begin
      tag_id_p[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++)
         tag_id_p[k] <= tag_id_p[k-1];
   end

   assign busy = |tag_vld_p;

endmodule
